// File: rtl/arm_regfile_banked_if.sv
// Bus bundle for arm_regfile_banked: decode read addresses, two writeback ports,
// SP bank select, PC advance and observation outputs.
interface arm_regfile_banked_if #(
    parameter int DATA_W = 32,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*4-1:0]      rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wa_en;
    logic [3:0]               wa_addr;
    logic [DATA_W-1:0]        wa_data;
    logic                     wb_en;
    logic [3:0]               wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     spsel;
    logic                     pc_en;
    logic [DATA_W-1:0]        pc_out;
    logic [DATA_W-1:0]        msp_out;
    logic [DATA_W-1:0]        psp_out;
    logic                     wr_collision;

    modport master (
        output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, spsel, pc_en,
        input  rd_data, pc_out, msp_out, psp_out, wr_collision
    );

    modport slave (
        input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, spsel, pc_en,
        output rd_data, pc_out, msp_out, psp_out, wr_collision
    );
endinterface

// File: rtl/arm_regfile_banked.sv
// Cortex-M0-class register file: R0-R12, banked MSP/PSP, LR, self-advancing PC,
// NUM_RD combinational read ports, two write ports (B wins on collision).

// One read port: architectural view plus optional same-cycle forwarding.
module arm_regfile_rd_port #(
    parameter int DATA_W = 32,
    parameter int BYPASS = 1
) (
    input  logic [3:0]                  addr,
    input  logic [15:0][DATA_W-1:0]     view,
    input  logic                        wa_go,
    input  logic [3:0]                  wa_addr,
    input  logic [DATA_W-1:0]           wa_fwd,
    input  logic                        wb_go,
    input  logic [3:0]                  wb_addr,
    input  logic [DATA_W-1:0]           wb_fwd,
    output logic [DATA_W-1:0]           data
);
    always_comb begin
        data = view[addr];
        if (BYPASS != 0) begin
            if (wb_go && wb_addr == addr)      data = wb_fwd;
            else if (wa_go && wa_addr == addr) data = wa_fwd;
        end
    end
endmodule

module arm_regfile_banked #(
    parameter int              DATA_W      = 32,
    parameter int              NUM_RD      = 2,
    parameter int              BYPASS      = 1,
    parameter logic [DATA_W-1:0] RESET_SP  = 'h0000_0400,
    parameter logic [DATA_W-1:0] RESET_PC  = 'h0000_0000,
    parameter int              PC_INC      = 2,
    parameter int              PC_READ_OFS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    arm_regfile_banked_if.slave  bus
);
    typedef logic [DATA_W-1:0] word_t;

    localparam word_t INC = word_t'(PC_INC);
    localparam word_t OFS = word_t'(PC_READ_OFS);

    logic [12:0][DATA_W-1:0] gpr, gpr_n;
    word_t lr, lr_n, msp, msp_n, psp, psp_n, pc, pc_n;
    logic  collision;

    // SP writes keep word alignment, PC writes keep halfword alignment.
    function automatic word_t mask_wr(input logic [3:0] addr, input word_t d);
        case (addr)
            4'd13:   mask_wr = {d[DATA_W-1:2], 2'b00};
            4'd15:   mask_wr = {d[DATA_W-1:1], 1'b0};
            default: mask_wr = d;
        endcase
    endfunction

    word_t      wa_val, wb_val, wa_fwd, wb_fwd;
    logic       wa_go, wb_go;
    logic [1:0]       we;
    logic [1:0][3:0]  wad;
    logic [1:0][DATA_W-1:0] wv;

    assign wa_go  = bus.wa_en & rst_n;
    assign wb_go  = bus.wb_en & rst_n;
    assign wa_val = mask_wr(bus.wa_addr, bus.wa_data);
    assign wb_val = mask_wr(bus.wb_addr, bus.wb_data);
    assign wa_fwd = wa_val + ((bus.wa_addr == 4'd15) ? OFS : '0);
    assign wb_fwd = wb_val + ((bus.wb_addr == 4'd15) ? OFS : '0);

    // Port B applied last so it wins a same-address collision.
    assign we  = {bus.wb_en, bus.wa_en};
    assign wad = {bus.wb_addr, bus.wa_addr};
    assign wv  = {wb_val, wa_val};

    always_comb begin
        gpr_n = gpr;
        lr_n  = lr;
        msp_n = msp;
        psp_n = psp;
        pc_n  = bus.pc_en ? pc + INC : pc;
        for (int p = 0; p < 2; p++) begin
            if (we[p]) begin
                case (wad[p])
                    4'd13:   if (bus.spsel) psp_n = wv[p]; else msp_n = wv[p];
                    4'd14:   lr_n = wv[p];
                    4'd15:   pc_n = wv[p];
                    default: gpr_n[wad[p]] = wv[p];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpr       <= '0;
            lr        <= '0;
            msp       <= RESET_SP;
            psp       <= '0;
            pc        <= RESET_PC;
            collision <= 1'b0;
        end else begin
            gpr       <= gpr_n;
            lr        <= lr_n;
            msp       <= msp_n;
            psp       <= psp_n;
            pc        <= pc_n;
            collision <= bus.wa_en & bus.wb_en & (bus.wa_addr == bus.wb_addr);
        end
    end

    logic [15:0][DATA_W-1:0] view;

    always_comb begin
        for (int i = 0; i < 13; i++) view[i] = gpr[i];
        view[13] = bus.spsel ? psp : msp;
        view[14] = lr;
        view[15] = pc + OFS;
    end

    logic [NUM_RD-1:0][DATA_W-1:0] rdv;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        arm_regfile_rd_port #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_rd (
            .addr    (bus.rd_addr[4*k +: 4]),
            .view    (view),
            .wa_go   (wa_go),
            .wa_addr (bus.wa_addr),
            .wa_fwd  (wa_fwd),
            .wb_go   (wb_go),
            .wb_addr (bus.wb_addr),
            .wb_fwd  (wb_fwd),
            .data    (rdv[k])
        );
    end

    assign bus.rd_data      = rdv;
    assign bus.pc_out       = pc;
    assign bus.msp_out      = msp;
    assign bus.psp_out      = psp;
    assign bus.wr_collision = collision;
endmodule

// File: doc/arm_regfile_banked.md
Name: arm_regfile_banked

Overview:
- Clocked, parametrised register file for the Cortex-M0-class core; successor to the combinational single-write-port file.
- 13 general registers R0-R12, banked stack pointer (MSP/PSP selected by spsel), LR at index 14, and a PC at index 15 with autonomous increment.
- N read ports, two write ports (ALU result, load writeback), optional same-cycle write-to-read bypass.
- Sits between decode (read addresses) and execute/memory writeback.

Parameters:
- DATA_W, 32, register width in bits (>=16).
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see pre-edge state.
- RESET_SP, 32'h0000_0400, MSP reset value (bits[1:0] must be 0).
- RESET_PC, 32'h0000_0000, PC reset value.
- PC_INC, 2, PC increment per pc_en cycle.
- PC_READ_OFS, 4, offset added to PC on any read of index 15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*4  read addresses; port k uses bits [4k+3:4k].
- rd_data  out  NUM_RD*DATA_W  read data; port k uses slice k.
- wa_en  in  1  write port A (ALU) enable.
- wa_addr  in  4  port A address.
- wa_data  in  DATA_W  port A data.
- wb_en  in  1  write port B (load writeback) enable.
- wb_addr  in  4  port B address.
- wb_data  in  DATA_W  port B data.
- spsel  in  1  0 = MSP active, 1 = PSP active.
- pc_en  in  1  advance PC by PC_INC this cycle.
- pc_out  out  DATA_W  current PC (registered, no offset).
- msp_out  out  DATA_W  current MSP.
- psp_out  out  DATA_W  current PSP.
- wr_collision  out  1  registered pulse: both ports wrote the same address in the previous cycle.

Behaviour:
- Reset (rst_n low, async): R0-R12, LR, PSP = 0; MSP = RESET_SP; PC = RESET_PC; wr_collision = 0. Outputs reflect reset values immediately; writes and pc_en are ignored while rst_n is low.
- Writes occur on the rising edge only. Index 13 writes the active SP (selected by spsel at that edge). SP writes force bits[1:0] = 0. Index 15 writes set PC = data with bit0 cleared.
- Port collision (wa_en & wb_en & equal address): port B wins. wr_collision = 1 for exactly the following cycle. Different addresses: both writes commit.
- PC update priority: a write to index 15 (either port) overrides pc_en that cycle. Otherwise pc_en gives PC <= PC + PC_INC, modulo 2^DATA_W (wraps, no flag).
- Reads are combinational:
  - Index 0-12 and 14 return the register.
  - Index 13 returns the SP currently selected by spsel.
  - Index 15 returns PC + PC_READ_OFS, modulo 2^DATA_W.
- Bypass (BYPASS=1): if a read address matches an enabled write this cycle, rd_data = the write value after the winner rule and SP/PC masking. For index 15 the forwarded value is (masked data) + PC_READ_OFS. For index 13 forwarding applies only to the active SP.
- BYPASS=0: reads return pre-edge register state.
- spsel change is effective combinationally for reads and at the same edge for writes. There is no copy between MSP and PSP.
- Reset asserted mid-cycle while a write is pending: the write is lost and the reset values hold.
- No X propagation: every index 0-15 is decoded. Unused read ports still decode.

Test Plan:
- Reset: hold rst_n=0 3 cycles, release → msp_out=32'h400, pc_out=0, rd_data for index 13 = 32'h400, index 15 = 4, wr_collision=0.
- Write/read with BYPASS=1: wa_en, R3=32'hDEAD_BEEF, read port 0 addr 3 same cycle → rd_data0=32'hDEAD_BEEF before the edge; after the edge, BYPASS=0 build returns the same value only post-edge.
- Collision: wa R5=32'h1111, wb R5=32'h2222 same cycle → R5=32'h2222, wr_collision=1 for one cycle, then 0.
- SP banking: spsel=1, write index 13=32'h0000_0207 → psp_out=32'h204, msp_out unchanged 32'h400; spsel=0, read index 13 → 32'h400.
- PC: 3 cycles pc_en → pc_out=6. Then pc_en plus wb write index 15=32'h0000_0101 → pc_out=32'h100, read index 15 =32'h104. Set PC=32'hFFFF_FFFE, pc_en → pc_out=0.
- Async reset mid-operation: drop rst_n between edges with wa_en active → all registers reset immediately, write not committed after release.
